seg_display_ctrl: RTL

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: four-digit multiplexed seven-segment display controller
// with a small memory-mapped register file (DIGITS, CTRL, STATUS).
//
// Optional feature: define SEG_BLINK_EN to compile in display blinking.
// Without it, CTRL bit1 is ignored on write and reads back as 0.
//
// Timing model: segments/an are registered from the current scan state, so
// they show idx and d[idx] one clock after either one changes.

module seg_display_ctrl #(
    parameter int unsigned REFRESH_CYCLES = 50000,
    parameter int unsigned BLINK_TICKS    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [6:0]  segments,
    output logic [3:0]  an
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    localparam logic [3:0] ADDR_DIGITS = 4'h0;
    localparam logic [3:0] ADDR_CTRL   = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;

    localparam logic [4:0] CODE_BLANK = 5'd16;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // Glyph ROM: active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            5'd10:   seg = 7'h08;   // A
            5'd11:   seg = 7'h03;   // b
            5'd12:   seg = 7'h46;   // C
            5'd13:   seg = 7'h21;   // d
            5'd14:   seg = 7'h06;   // E
            5'd15:   seg = 7'h0E;   // F
            5'd17:   seg = 7'h09;   // H
            5'd18:   seg = 7'h47;   // L
            5'd19:   seg = 7'h0C;   // P
            5'd20:   seg = 7'h41;   // U
            5'd21:   seg = 7'h3F;   // dash
            default: seg = SEG_OFF; // 16 and 22..31 are blank
        endcase
        return seg;
    endfunction

    // Architectural state
    logic [3:0][4:0]   digits_q, digits_d;
    logic              en_q, en_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;

    logic wr_digits;
    logic wr_ctrl;
    logic scan_run;
    logic scan_adv;
    logic blank;
    logic [1:0] ctrl_rd;

    assign wr_digits = we && (addr == ADDR_DIGITS);
    assign wr_ctrl   = we && (addr == ADDR_CTRL);

    // Scan runs only while enable is both held and staying set, so a clear
    // zeroes counter and idx on the very edge that takes the write.
    assign scan_run = en_q && en_d;
    assign scan_adv = scan_run && (cnt_q == CNT_LAST);

    // Register-file writes
    always_comb begin
        digits_d = digits_q;
        en_d     = en_q;
        if (wr_digits) begin
            digits_d = {wdata[28:24], wdata[20:16], wdata[12:8], wdata[4:0]};
        end
        if (wr_ctrl) begin
            en_d = wdata[0];
        end
    end

    // Refresh counter and digit index
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!scan_run) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (scan_adv) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned TICK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BLINK_TICKS - 1);

    logic              blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [TICK_W-1:0] tick_q, tick_d;

    // Blink control bit and phase toggling every BLINK_TICKS digit advances
    always_comb begin
        blink_d = wr_ctrl ? wdata[1] : blink_q;
        tick_d  = tick_q;
        phase_d = phase_q;
        if (!scan_run) begin
            tick_d  = '0;
            phase_d = 1'b0;
        end else if (scan_adv) begin
            if (tick_q == TICK_LAST) begin
                tick_d  = '0;
                phase_d = ~phase_q;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    // Blink state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= 1'b0;
            phase_q <= 1'b0;
            tick_q  <= '0;
        end else begin
            blink_q <= blink_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
        end
    end

    assign blank   = blink_q && phase_q;
    assign ctrl_rd = {blink_q, en_q};
`else
    assign blank   = 1'b0;
    assign ctrl_rd = {1'b0, en_q};
`endif

    // Display output drive, computed from the current scan state
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (en_q && !blank) begin
            seg_d = seg_decode(digits_q[idx_q]);
            an_d  = ~(4'b0001 << idx_q);
        end
    end

    // Read mux; result is registered so rdata lags addr by one cycle
    always_comb begin
        case (addr)
            ADDR_DIGITS: rdata_d = {3'b000, digits_q[3], 3'b000, digits_q[2],
                                    3'b000, digits_q[1], 3'b000, digits_q[0]};
            ADDR_CTRL:   rdata_d = {30'b0, ctrl_rd};
            ADDR_STATUS: rdata_d = {30'b0, idx_q};
            default:     rdata_d = 32'h0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q <= {4{CODE_BLANK}};
            en_q     <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            rdata_q  <= 32'h0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
        end else begin
            digits_q <= digits_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign rdata    = rdata_q;
    assign segments = seg_q;
    assign an       = an_q;

    // Padding bits between the packed digit fields carry no meaning.
    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:29], wdata[23:21], wdata[15:13], wdata[7:5]};

endmodule
